// File: rtl/walk_pkg.sv
// Shared types for the walking-pattern stimulus source.
//   walk_state_e : sequencer states (IDLE, RUN, DONE)
//   walk_mode_e  : pattern polarity (WALK_ONE = single 1, WALK_ZERO = single 0)
package walk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } walk_state_e;

    typedef enum logic {
        WALK_ONE  = 1'b0,
        WALK_ZERO = 1'b1
    } walk_mode_e;

endpackage

// File: rtl/walk_pattern_gen.sv
// Walking-pattern stimulus source for the bit-transform stage.
// On an accepted start it emits WIDTH+1 beats over a valid/ready handshake:
// a single 1 (mode=0) or 0 (mode=1) walking from bit 0 to bit WIDTH-1, then a
// flush beat (all 0 / all 1) once the bit has shifted out, then a done pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle request, honoured only in IDLE
//   mode       0 = walking-one, 1 = walking-zero, latched with start
//   out_valid  beat valid
//   out_ready  consumer accept
//   pattern    current beat (0 whenever out_valid is low)
//   beat_idx   current beat index, 0..WIDTH
//   out_last   marks beat WIDTH
//   busy       high while beats are being presented
//   done       one-cycle pulse after the last beat is accepted
//   loop       (only with WALK_PATTERN_LOOP_EN) latched with start; while it
//              stays high, the final beat wraps straight back to beat 0
//
// Build option: define WALK_PATTERN_LOOP_EN to add the loop port.
module walk_pattern_gen
    import walk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       mode,
`ifdef WALK_PATTERN_LOOP_EN
    input  logic                       loop,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           pattern,
    output logic [$clog2(WIDTH+1)-1:0] beat_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned IDXW = $clog2(WIDTH + 1);
    localparam logic [IDXW-1:0] PRELAST_IDX = IDXW'(WIDTH - 1);

    localparam logic [WIDTH-1:0] FIRST_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] FIRST_ZERO = {{(WIDTH-1){1'b1}}, 1'b0};

    walk_state_e state;
    walk_mode_e  mode_q;
    logic        wrap;

`ifdef WALK_PATTERN_LOOP_EN
    logic loop_q;

    // Wrap needs both the latched request and the live input: dropping loop
    // lets the current pass finish through DONE.
    assign wrap = loop_q && loop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loop_q <= 1'b0;
        end else if (state == IDLE && start) begin
            loop_q <= loop;
        end
    end
`else
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= WALK_ONE;
            out_valid <= 1'b0;
            pattern   <= '0;
            beat_idx  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        mode_q    <= walk_mode_e'(mode);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        beat_idx  <= '0;
                        out_last  <= 1'b0;
                        pattern   <= mode ? FIRST_ZERO : FIRST_ONE;
                    end
                end

                RUN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            if (wrap) begin
                                pattern  <= (mode_q == WALK_ZERO) ? FIRST_ZERO : FIRST_ONE;
                                beat_idx <= '0;
                                out_last <= 1'b0;
                            end else begin
                                state     <= DONE;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                pattern   <= '0;
                                beat_idx  <= '0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            // Fill bit equals the background polarity, so the
                            // flush beat appears when the walking bit leaves.
                            pattern  <= {pattern[WIDTH-2:0], (mode_q == WALK_ZERO)};
                            beat_idx <= beat_idx + 1'b1;
                            out_last <= (beat_idx == PRELAST_IDX);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/walk_pattern_gen.md
Name: walk_pattern_gen

Overview:
- Sequential stimulus source that feeds the bit-transform stage (`in` bus, WIDTH bits) one walking pattern per handshake.
- Replaces hand-written shift loops in benches and lets the transform stage be exercised in-system.
- On `start`, emits WIDTH+1 beats: a single 1 (or 0) walking from bit 0 to bit WIDTH-1, then a final flush beat after the bit has shifted out.

Parameters:
- WIDTH, 8, pattern width in bits; legal range ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
- mode  input  1  0 = walking-one, 1 = walking-zero; latched on accepted start.
- out_valid  output  1  pattern beat valid.
- out_ready  input  1  consumer accepts beat when high with out_valid.
- pattern  output  WIDTH  current beat, to the transform stage `in`.
- beat_idx  output  $clog2(WIDTH+1)  index of current beat, 0..WIDTH.
- out_last  output  1  high with out_valid on beat WIDTH.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset, sampled on clk when rst_n=0:
  - All outputs go to 0, FSM goes to IDLE, mode latch cleared.
  - Applies mid-sequence: the sequence is aborted, no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at cycle t → RUN at t+1 with out_valid=1, busy=1, beat_idx=0.
  - Beat 0 pattern: mode0 = 0…01, mode1 = 1…10.
- RUN:
  - Beat n, n < WIDTH: mode0 = 1<<n; mode1 = ~(1<<n).
  - Beat WIDTH: mode0 = all zeros; mode1 = all ones. out_last=1.
  - Handshake occurs when out_valid && out_ready.
  - While out_valid && !out_ready: pattern, beat_idx and out_last hold stable.
  - On a handshake of beat n < WIDTH, beat n+1 is presented the next cycle (no bubble; full-throughput when out_ready is tied high).
  - On the handshake of beat WIDTH → DONE the next cycle.
- DONE:
  - Lasts exactly one cycle: out_valid=0, busy=0, done=1, pattern=0, then IDLE.
- start handling:
  - Ignored in RUN and DONE (no queuing).
  - start in the same cycle as the DONE pulse is dropped.
- mode changes after start have no effect until the next accepted start.
- Outputs are registered; pattern is 0 whenever out_valid=0.
- Total latency, out_ready held high: start at t → beats at t+1..t+WIDTH+1 → done at t+WIDTH+2.
- Width rules:
  - beat_idx counter is $clog2(WIDTH+1) bits.
  - Pattern is generated by shifting the registered value left by one, inserting 0 (mode0) or 1 (mode1) at bit 0.
  - The beat-WIDTH pattern falls out naturally from that shift.

Optional Feature:
- Macro: WALK_PATTERN_LOOP_EN.
- Defined:
  - Adds input port `loop` (1 bit), sampled with start.
  - If latched loop=1, the handshake on beat WIDTH returns to beat 0 of the same mode with no bubble and no DONE/done pulse.
  - The sequence ends only when a handshake on beat WIDTH occurs while `loop` is currently low; that then goes through DONE as normal.
- Not defined: the port is absent and the behaviour is exactly as above.

Decomposition:
- Package walk_pkg:
  - walk_state_e enum {IDLE, RUN, DONE}.
  - walk_mode_e enum {WALK_ONE=0, WALK_ZERO=1}.
- WIDTH-dependent widths are local parameters in the module.
- No sub-module: FSM, shift register and beat counter fit in one module.

Test Plan:
- WIDTH=8, mode0, out_ready=1, start at t:
  - pattern 01,02,04,08,10,20,40,80,00 at t+1..t+9.
  - out_last only at t+9, done at t+10, busy high t+1..t+9.
- mode1, out_ready=1: pattern FE,FD,FB,F7,EF,DF,BF,7F,FF; out_last on FF.
- mode0 with out_ready low for 3 cycles on beat 3: pattern holds 08, beat_idx holds 3; 10 appears the cycle after ready rises.
- start pulsed during RUN and during the DONE cycle: no restart, exactly one done pulse per accepted start.
- rst_n=0 on beat 4: next cycle all outputs 0, no done; a new start gives 01 first.
- WALK_PATTERN_LOOP_EN defined, loop=1 for 20 cycles then 0:
  - Pattern wraps 00→01 with no gap.
  - Sequence ends after the next 00 beat handshake with done=1.
